uart_rx: RTL

- UART receiver that sits directly downstream of the baud/oversampling tick generator.
- Consumes the 16x oversampling tick and the serial line, and recovers 8N1 frames (LSB first).
- Presents each received byte with a one-cycle done strobe to the next stage (FIFO / interface logic).
- Detects start-bit glitches and framing errors.

---
 rtl/uart_rx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx -- oversampled UART receiver (8N1 by default, LSB first).
//
// Sits behind the baud/oversampling tick generator. It hunts for a falling
// edge on the line, confirms the start bit at its midpoint, then samples each
// data bit once per bit period (mid-bit). The byte and its status flags are
// presented together with a single-cycle done strobe.
//
// Optional build macro: UART_RX_PARITY_EN
//   Adds an even-parity bit between the data bits and the stop bit, plus the
//   o_parityError output.
//
// Ports:
//   i_clk          system clock
//   i_reset        asynchronous, active-high reset
//   i_tick         one-cycle oversampling pulse (OVERSAMPLING_FACTOR per bit)
//   i_rx           serial line, idle high, already synchronised upstream
//   o_data         last received byte, held until the next completed frame
//   o_rxDone       one-cycle strobe: frame complete, o_data/flags valid
//   o_frameError   stop bit sampled low for the last reported frame
//   o_parityError  (parity build only) parity mismatch for the last frame
//
// States:
//   IDLE   | line idle, waiting for a low level on i_rx
//   START  | counting to the middle of the start bit to confirm it
//   DATA   | sampling data bits, one per OVERSAMPLING_FACTOR ticks
//   PARITY | (parity build only) sampling the parity bit
//   STOP   | waiting SB_TICKS ticks in the stop bit, then reporting the frame

module uart_rx #(
    parameter int DATA_BITS           = 8,
    parameter int SB_TICKS            = 16,
    parameter int OVERSAMPLING_FACTOR = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rxDone,
`ifdef UART_RX_PARITY_EN
    output logic                 o_frameError,
    output logic                 o_parityError
`else
    output logic                 o_frameError
`endif
);

    localparam int S_MAX = (OVERSAMPLING_FACTOR > SB_TICKS) ? OVERSAMPLING_FACTOR - 1
                                                            : SB_TICKS - 1;
    localparam int S_W   = (S_MAX > 0) ? $clog2(S_MAX + 1) : 1;
    localparam int N_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [S_W-1:0] S_MID      = S_W'(OVERSAMPLING_FACTOR / 2 - 1);
    localparam logic [S_W-1:0] S_BIT_END  = S_W'(OVERSAMPLING_FACTOR - 1);
    localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICKS - 1);
    localparam logic [N_W-1:0] N_LAST     = N_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [S_W-1:0]       s_reg, s_next;
    logic [N_W-1:0]       n_reg, n_next;
    logic [DATA_BITS-1:0] b_reg, b_next;
    logic [DATA_BITS-1:0] data_next;
    logic                 done_next;
    logic                 ferr_next;
`ifdef UART_RX_PARITY_EN
    logic                 p_reg, p_next;
    logic                 perr_next;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            s_reg         <= '0;
            n_reg         <= '0;
            b_reg         <= '0;
            o_data        <= '0;
            o_rxDone      <= 1'b0;
            o_frameError  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            p_reg         <= 1'b0;
            o_parityError <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            s_reg         <= s_next;
            n_reg         <= n_next;
            b_reg         <= b_next;
            o_data        <= data_next;
            o_rxDone      <= done_next;
            o_frameError  <= ferr_next;
`ifdef UART_RX_PARITY_EN
            p_reg         <= p_next;
            o_parityError <= perr_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        data_next  = o_data;
        done_next  = 1'b0;
        ferr_next  = o_frameError;
`ifdef UART_RX_PARITY_EN
        p_next     = p_reg;
        perr_next  = o_parityError;
`endif

        case (state_reg)
            IDLE: begin
                // Edge hunt runs every clock; the tick only paces later states.
                if (!i_rx) begin
                    state_next = START;
                    s_next     = '0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (s_reg == S_MID) begin
                        if (!i_rx) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            // Line went high again before mid-bit: glitch.
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            DATA: begin
                if (i_tick) begin
                    if (s_reg == S_BIT_END) begin
                        s_next = '0;
                        // LSB arrives first, so shift right and insert at the MSB.
                        b_next = DATA_BITS'({i_rx, b_reg} >> 1);
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = PARITY;
`else
                            state_next = STOP;
`endif
                        end else begin
                            n_next = n_reg + N_W'(1);
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (i_tick) begin
                    if (s_reg == S_BIT_END) begin
                        p_next     = i_rx;
                        s_next     = '0;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`endif

            STOP: begin
                if (i_tick) begin
                    if (s_reg == S_STOP_END) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                        data_next  = b_reg;
                        ferr_next  = ~i_rx;
`ifdef UART_RX_PARITY_EN
                        perr_next  = ^{b_reg, p_reg};
`endif
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end

            default: state_next = IDLE;
        endcase
    end

endmodule
